// File: rtl/controller_poller.sv
// controller_poller: drives the shared latch/clock lines of up to NUM_PADS
// serial gamepads, runs timer-driven or on-demand read cycles and publishes a
// coherent per-pad button snapshot together with newly-pressed edges.
module controller_poller #(
    parameter int NUM_PADS    = 2,
    parameter int HALF_BIT    = 6,
    parameter int POLL_PERIOD = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PADS-1:0]     pad_data,
    output logic                    pad_latch,
    output logic                    pad_clk,
    input  logic                    poll_enable,
    input  logic                    poll_now,
    output logic [12*NUM_PADS-1:0]  btns,
    output logic [12*NUM_PADS-1:0]  pressed,
    output logic [NUM_PADS-1:0]     present,
    output logic                    sample_valid,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        GAP    = 3'd2,
        BIT_LO = 3'd3,
        BIT_HI = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int          CW       = $clog2(2 * HALF_BIT) + 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(2 * HALF_BIT - 1);
    localparam logic [CW-1:0] HB_LAST  = CW'(HALF_BIT - 1);
    localparam logic [31:0] RELOAD   = 32'(POLL_PERIOD - 1);

    state_t               state;
    state_t               next_state;
    logic [CW-1:0]        phase_cnt;
    logic [3:0]           bit_idx;
    logic [31:0]          timer;
    logic                 pending;
    logic [15:0]          raw [NUM_PADS];

    logic                 phase_end;
    logic                 expiry;
    logic                 trigger;
    logic                 latch_d;
    logic                 clk_d;
    logic                 busy_d;
    logic [NUM_PADS-1:0]  present_d;
    logic [12*NUM_PADS-1:0] new_bits;

    assign expiry  = poll_enable && (timer == 32'd0);
    assign trigger = poll_now || pending || expiry;

    // Flag the last cycle of the current state's phase.
    always_comb begin
        phase_end = 1'b0;
        case (state)
            LATCH:               phase_end = (phase_cnt == LAT_LAST);
            GAP, BIT_LO, BIT_HI: phase_end = (phase_cnt == HB_LAST);
            DONE:                phase_end = 1'b1;
            default:             phase_end = 1'b0;
        endcase
    end

    // Next-state logic for the read-cycle sequencer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (trigger) next_state = LATCH;
                else         next_state = IDLE;
            end
            LATCH: begin
                if (phase_end) next_state = GAP;
                else           next_state = LATCH;
            end
            GAP: begin
                if (phase_end) next_state = BIT_LO;
                else           next_state = GAP;
            end
            BIT_LO: begin
                if (phase_end) next_state = BIT_HI;
                else           next_state = BIT_LO;
            end
            BIT_HI: begin
                if (phase_end && (bit_idx == 4'd15)) next_state = DONE;
                else if (phase_end)                  next_state = BIT_LO;
                else                                 next_state = BIT_HI;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register with phase counter and bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= {CW{1'b0}};
            bit_idx   <= 4'd0;
        end else begin
            state <= next_state;
            if ((next_state != state) || (state == IDLE)) phase_cnt <= {CW{1'b0}};
            else                                          phase_cnt <= phase_cnt + CW'(1);
            if (state == LATCH)                    bit_idx <= 4'd0;
            else if ((state == BIT_HI) && phase_end) bit_idx <= bit_idx + 4'd1;
            else                                   bit_idx <= bit_idx;
        end
    end

    // Poll timer: counts while enabled, reloads on expiry or on a started poll.
    always_ff @(posedge clk) begin
        if (rst || !poll_enable)                    timer <= RELOAD;
        else if (expiry || ((state == IDLE) && trigger)) timer <= RELOAD;
        else                                        timer <= timer - 32'd1;
    end

    // Pending flag remembers one request that arrived while a poll was running.
    always_ff @(posedge clk) begin
        if (rst)                       pending <= 1'b0;
        else if (state == IDLE)        pending <= 1'b0;
        else if (poll_now || expiry)   pending <= 1'b1;
        else                           pending <= pending;
    end

    // Per-pad shift capture: cleared during latch, one bit per BIT_LO end.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PADS; p++) begin
            if (rst || (state == LATCH))             raw[p] <= 16'h0000;
            else if ((state == BIT_LO) && phase_end) raw[p][bit_idx] <= ~pad_data[p];
            else                                     raw[p] <= raw[p];
        end
    end

    // Pin levels and busy are derived from the state being entered so the
    // registered outputs line up with the state itself.
    always_comb begin
        latch_d = (next_state == LATCH);
        clk_d   = (next_state == BIT_HI);
        busy_d  = (next_state != IDLE);
    end

    // Snapshot decode: a pad is present only if its ID nibble reads all zero.
    always_comb begin
        present_d = {NUM_PADS{1'b0}};
        new_bits  = {(12*NUM_PADS){1'b0}};
        for (int p = 0; p < NUM_PADS; p++) begin
            present_d[p] = (raw[p][15:12] == 4'b0000);
            if (present_d[p]) new_bits[12*p +: 12] = raw[p][11:0];
            else              new_bits[12*p +: 12] = 12'h000;
        end
    end

    // Registered outputs; the snapshot only changes in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_latch    <= 1'b0;
            pad_clk      <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            btns         <= {(12*NUM_PADS){1'b0}};
            pressed      <= {(12*NUM_PADS){1'b0}};
            present      <= {NUM_PADS{1'b0}};
        end else begin
            pad_latch    <= latch_d;
            pad_clk      <= clk_d;
            busy         <= busy_d;
            sample_valid <= (state == DONE);
            if (state == DONE) begin
                btns    <= new_bits;
                pressed <= new_bits & ~btns;
                present <= present_d;
            end else begin
                btns    <= btns;
                pressed <= pressed;
                present <= present;
            end
        end
    end

endmodule

// File: tb/tb_controller_poller.sv
// Self-checking bench for controller_poller: a cycle-offset reference model
// plus directed scenarios with literal expectations and a random phase.
module tb_controller_poller;

    localparam int N = 2;
    localparam int H = 2;
    localparam int P = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     pad_data;
    logic             pad_latch, pad_clk;
    logic             poll_enable, poll_now;
    logic [12*N-1:0]  btns, pressed;
    logic [N-1:0]     present;
    logic             sample_valid, busy;

    controller_poller #(.NUM_PADS(N), .HALF_BIT(H), .POLL_PERIOD(P)) dut (
        .clk(clk), .rst(rst), .pad_data(pad_data), .pad_latch(pad_latch),
        .pad_clk(pad_clk), .poll_enable(poll_enable), .poll_now(poll_now),
        .btns(btns), .pressed(pressed), .present(present),
        .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit cmp_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- pad model (stimulus) ----------------
    logic [11:0] pad_btn [N];
    logic [N-1:0] pad_conn;
    int   pad_idx = 0;
    logic prev_clk = 1'b0;
    logic [15:0] line_v;

    always @(negedge clk) begin
        if (pad_latch === 1'b1) pad_idx = 0;
        else if (pad_clk === 1'b1 && !prev_clk) pad_idx = pad_idx + 1;
        prev_clk = (pad_clk === 1'b1);
    end

    always_comb begin
        line_v = 16'h0000;
        for (int p = 0; p < N; p++) begin
            line_v = {4'b1111, ~pad_btn[p]};
            pad_data[p] = 1'b0;
            if (pad_conn[p]) begin
                if (pad_idx < 16) pad_data[p] = line_v[pad_idx[3:0]];
                else              pad_data[p] = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    // k counts cycles from the first latch cycle; DONE sits at k = 35H.
    bit          m_busy = 0;
    int          m_k = 0;
    bit          m_pend = 0;
    int          m_en = 0;
    logic [15:0] m_raw [N];
    logic [12*N-1:0] m_btns = '0, m_pressed = '0;
    logic [N-1:0]    m_present = '0;
    bit          m_sv = 0;

    always @(posedge clk) begin
        bit exp_t, started, pres;
        logic [11:0] nb;
        int j;
        if (rst) begin
            m_busy = 0; m_k = 0; m_pend = 0; m_en = 0; m_sv = 0;
            m_btns = '0; m_pressed = '0; m_present = '0;
        end else begin
            m_sv = 0;
            started = 0;
            exp_t = poll_enable && (m_en == P - 1);
            if (!m_busy) begin
                if (poll_now || m_pend || exp_t) begin
                    m_busy = 1; m_k = 0; m_pend = 0; started = 1;
                    for (int p = 0; p < N; p++) m_raw[p] = 16'h0000;
                end
            end else begin
                if (poll_now || exp_t) m_pend = 1;
                j = m_k - 3 * H;
                if (m_k >= 3 * H && m_k < 35 * H && (j % (2 * H)) == H - 1)
                    for (int p = 0; p < N; p++) m_raw[p][j / (2 * H)] = ~pad_data[p];
                if (m_k == 35 * H) begin
                    for (int p = 0; p < N; p++) begin
                        pres = (m_raw[p][15:12] == 4'b0000);
                        nb = pres ? m_raw[p][11:0] : 12'h000;
                        m_pressed[12*p +: 12] = nb & ~m_btns[12*p +: 12];
                        m_btns[12*p +: 12] = nb;
                        m_present[p] = pres;
                    end
                    m_sv = 1;
                    m_busy = 0;
                end else begin
                    m_k = m_k + 1;
                end
            end
            if (!poll_enable || started || exp_t) m_en = 0;
            else                                   m_en = m_en + 1;
        end
    end

    // ---------------- compare + event monitor ----------------
    int lat_q[$];
    int sv_q[$];
    logic prev_lat = 1'b0;

    always @(negedge clk) begin
        bit e_latch, e_clk;
        int j;
        if (cmp_on) begin
            j = m_k - 3 * H;
            e_latch = m_busy && (m_k < 2 * H);
            e_clk   = m_busy && (m_k >= 3 * H) && (m_k < 35 * H) && (((j / H) % 2) == 1);
            check("pad_latch", {63'd0, pad_latch}, {63'd0, e_latch});
            check("pad_clk", {63'd0, pad_clk}, {63'd0, e_clk});
            check("busy", {63'd0, busy}, {63'd0, m_busy});
            check("sample_valid", {63'd0, sample_valid}, {63'd0, m_sv});
            check("btns", {40'd0, btns}, {40'd0, m_btns});
            check("pressed", {40'd0, pressed}, {40'd0, m_pressed});
            check("present", {62'd0, present}, {62'd0, m_present});
            if (pad_latch === 1'b1 && !prev_lat) lat_q.push_back(cyc);
            if (sample_valid === 1'b1) sv_q.push_back(cyc);
            prev_lat = (pad_latch === 1'b1);
        end
    end

    // One on-demand poll, measuring pin activity between L and sample_valid.
    task automatic do_poll(output int lc, output int sc, output int lat_hi,
                           output int clk_pulses, output int clk_hi);
        logic pc;
        pc = 1'b0;
        lc = -1; sc = -1; lat_hi = 0; clk_pulses = 0; clk_hi = 0;
        @(posedge clk); #1 poll_now = 1'b1;
        @(posedge clk); #1 poll_now = 1'b0;
        for (int i = 0; i < 200 && sc < 0; i++) begin
            @(negedge clk);
            if (pad_latch === 1'b1) begin
                lat_hi++;
                if (lc < 0) lc = cyc;
            end
            if (pad_clk === 1'b1) clk_hi++;
            if (pad_clk === 1'b1 && !pc) clk_pulses++;
            pc = (pad_clk === 1'b1);
            if (sample_valid === 1'b1) sc = cyc;
        end
        check("poll_completes", {63'd0, (sc >= 0)}, 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int lc, sc, lh, cp, ch, n, ns, k;
        rst = 1'b1; poll_enable = 1'b0; poll_now = 1'b0;
        pad_conn = '0;
        for (int p = 0; p < N; p++) pad_btn[p] = 12'h000;
        @(posedge clk); #1 cmp_on = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {40'd0, pad_latch, pad_clk, busy, sample_valid, btns},
              64'd0);
        check("reset_pressed_present", {38'd0, pressed, present}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Idle with polling disabled: no latch activity.
        n = lat_q.size();
        repeat (500) @(posedge clk);
        check("no_auto_poll", 64'(lat_q.size() - n), 64'd0);

        // Single poll: pad 0 has bits 0 and 11 pressed, pad 1 line low.
        pad_conn = 2'b01; pad_btn[0] = 12'h801; pad_btn[1] = 12'h000;
        do_poll(lc, sc, lh, cp, ch);
        check("latch_cycles", 64'(lh), 64'd4);
        check("clk_pulses", 64'(cp), 64'd16);
        check("clk_high_cycles", 64'(ch), 64'd32);
        check("sv_offset", 64'(sc - lc), 64'd71);
        check("btns_pad0", {52'd0, btns[11:0]}, 64'h801);
        check("btns_pad1", {52'd0, btns[23:12]}, 64'h000);
        check("present", {62'd0, present}, 64'h1);
        check("pressed_pad0", {52'd0, pressed[11:0]}, 64'h801);

        // Edge detect: bit 11 released, bit 3 newly pressed.
        pad_btn[0] = 12'h009;
        do_poll(lc, sc, lh, cp, ch);
        check("edge_btns", {52'd0, btns[11:0]}, 64'h009);
        check("edge_pressed", {52'd0, pressed[11:0]}, 64'h008);

        // Periodic polling.
        wait_idle("idle_before_periodic");
        n = lat_q.size();
        @(posedge clk); #1 poll_enable = 1'b1;
        k = 0;
        while (lat_q.size() < n + 3 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("periodic_seen", {63'd0, (lat_q.size() >= n + 3)}, 64'd1);
        if (lat_q.size() >= n + 3) begin
            check("period_1", 64'(lat_q[n+1] - lat_q[n]), 64'd200);
            check("period_2", 64'(lat_q[n+2] - lat_q[n+1]), 64'd200);
        end
        wait_idle("idle_after_periodic");
        @(posedge clk); #1 poll_enable = 1'b0;
        n = lat_q.size();
        repeat (500) @(posedge clk);
        check("periodic_stopped", 64'(lat_q.size() - n), 64'd0);

        // Collision: requests during bit 5 and bit 9 give exactly one extra poll.
        pad_btn[0] = 12'h5A5; pad_conn = 2'b11; pad_btn[1] = 12'h0F0;
        n = lat_q.size(); ns = sv_q.size();
        @(posedge clk); #1 poll_now = 1'b1;
        @(posedge clk); #1 poll_now = 1'b0;
        repeat (28) @(posedge clk);
        #1 poll_now = 1'b1;
        @(posedge clk); #1 poll_now = 1'b0;
        repeat (15) @(posedge clk);
        #1 poll_now = 1'b1;
        @(posedge clk); #1 poll_now = 1'b0;
        repeat (300) @(posedge clk);
        check("collision_polls", 64'(lat_q.size() - n), 64'd2);
        if (lat_q.size() >= n + 2 && sv_q.size() >= ns + 1)
            check("collision_restart", 64'(lat_q[n+1] - sv_q[ns]), 64'd1);
        check("collision_btns", {40'd0, btns}, {40'd0, 12'h0F0, 12'h5A5});

        // Reset in the middle of bit 7.
        @(posedge clk); #1 poll_now = 1'b1;
        @(posedge clk); #1 poll_now = 1'b0;
        repeat (36) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_clk", {63'd0, pad_clk}, 64'd0);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_btns", {40'd0, btns}, 64'd0);
        ns = sv_q.size();
        repeat (100) @(posedge clk);
        check("rst_no_sv", 64'(sv_q.size() - ns), 64'd0);
        pad_conn = 2'b01; pad_btn[0] = 12'h3C3;
        do_poll(lc, sc, lh, cp, ch);
        check("clean_latch", 64'(lh), 64'd4);
        check("clean_sv_offset", 64'(sc - lc), 64'd71);
        check("clean_btns", {40'd0, btns}, 64'h3C3);
        check("clean_pressed", {40'd0, pressed}, 64'h3C3);

        // Random phase against the model.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            poll_now = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 299) == 0) poll_enable = ~poll_enable;
            rst = ($urandom_range(0, 1999) == 0);
            if (!m_busy && $urandom_range(0, 19) == 0) begin
                pad_conn = 2'($urandom_range(0, 3));
                for (int p = 0; p < N; p++) pad_btn[p] = 12'($urandom);
            end
        end
        #1 poll_now = 1'b0; rst = 1'b0; poll_enable = 1'b0;
        repeat (100) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
